// File: rtl/cl_lane_scheduler_if.sv
// cl_lane_scheduler_if: FIFO-shell and worker-lane signals seen by the lane scheduler
interface cl_lane_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4
);
    logic                            data_empty;
    logic                            data_rd;
    logic [DATA_WIDTH-1:0]           data_din;
    logic                            data_full;
    logic                            data_wr;
    logic [DATA_WIDTH-1:0]           data_dout;
    logic [NUM_LANES-1:0]            lane_req_valid;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_req_data;
    logic [NUM_LANES-1:0]            lane_req_ready;
    logic [NUM_LANES-1:0]            lane_rsp_valid;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_rsp_data;
    logic [NUM_LANES-1:0]            lane_rsp_ready;

    modport master (
        input  data_empty, data_din, data_full, lane_req_ready, lane_rsp_valid, lane_rsp_data,
        output data_rd, data_wr, data_dout, lane_req_valid, lane_req_data, lane_rsp_ready
    );

    modport slave (
        output data_empty, data_din, data_full, lane_req_ready, lane_rsp_valid, lane_rsp_data,
        input  data_rd, data_wr, data_dout, lane_req_valid, lane_req_data, lane_rsp_ready
    );
endinterface

// File: rtl/cl_lane_scheduler.sv
// cl_lane_scheduler: round-robin dispatch of FIFO words to worker lanes, in-order collection of results
module cl_lane_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    parameter int LANE_IDX_W = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    cl_lane_scheduler_if.master   bus,
    output logic [LANE_IDX_W:0]   inflight,
    output logic                  err_unexpected
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, ISSUE} state_t;

    state_t                  state, state_nxt;
    logic [LANE_IDX_W-1:0]   d_ptr, c_ptr;
    logic [NUM_LANES-1:0]    outstanding, outstanding_nxt, set_mask, clr_mask;
    logic [LANE_IDX_W:0]     count_nxt;
    logic                    cooldown, issue_done, fire;

    assign issue_done      = (state == ISSUE) && bus.lane_req_ready[d_ptr];
    assign fire            = outstanding[c_ptr] && bus.lane_rsp_valid[c_ptr] && !bus.data_full && !cooldown;
    assign set_mask        = issue_done ? NUM_LANES'(1) << d_ptr : '0;
    assign clr_mask        = fire ? NUM_LANES'(1) << c_ptr : '0;
    assign outstanding_nxt = (outstanding | set_mask) & ~clr_mask;
    assign bus.lane_rsp_ready = clr_mask;

    // popcount of the post-edge outstanding set so inflight tracks it on the same edge
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            count_nxt = count_nxt + (LANE_IDX_W+1)'(outstanding_nxt[i]);
    end

    // dispatch FSM state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    // dispatch FSM next state; pop only into a free lane, and never while held in reset
    always_comb begin
        state_nxt   = state;
        bus.data_rd = 1'b0;
        case (state)
            IDLE: if (reset_n && !bus.data_empty && !outstanding[d_ptr]) begin
                bus.data_rd = 1'b1;
                state_nxt   = RD_WAIT;
            end
            RD_WAIT: state_nxt = ISSUE;
            ISSUE:   state_nxt = bus.lane_req_ready[d_ptr] ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // request side: capture popped word for the current lane, hold until the lane takes it
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            d_ptr              <= '0;
            bus.lane_req_valid <= '0;
            bus.lane_req_data  <= '0;
        end else begin
            if (state == RD_WAIT) begin
                bus.lane_req_valid <= NUM_LANES'(1) << d_ptr;
                bus.lane_req_data[d_ptr*DATA_WIDTH +: DATA_WIDTH] <= bus.data_din;
            end
            if (issue_done) begin
                bus.lane_req_valid <= '0;
                d_ptr              <= d_ptr + 1'b1;
            end
        end

    // collect side: accept only the oldest lane, push one word at most every other cycle
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            c_ptr          <= '0;
            outstanding    <= '0;
            inflight       <= '0;
            cooldown       <= 1'b0;
            bus.data_wr    <= 1'b0;
            bus.data_dout  <= '0;
            err_unexpected <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            inflight    <= count_nxt;
            cooldown    <= fire;
            bus.data_wr <= fire;
            if (fire) begin
                bus.data_dout <= bus.lane_rsp_data[c_ptr*DATA_WIDTH +: DATA_WIDTH];
                c_ptr         <= c_ptr + 1'b1;
            end
            if (|(bus.lane_rsp_valid & ~outstanding)) err_unexpected <= 1'b1;
        end
endmodule

// File: tb/tb_cl_lane_scheduler.sv
// tb_cl_lane_scheduler: lane/FIFO models plus an order-preserving reference for the lane scheduler
module tb_cl_lane_scheduler;
    localparam int DW = 32;
    localparam int NL = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] inflight;
    logic err_unexpected;

    always #5 clock = ~clock;

    cl_lane_scheduler_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    cl_lane_scheduler #(.DATA_WIDTH(DW), .NUM_LANES(NL), .LANE_IDX_W(2)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .inflight(inflight),
        .err_unexpected(err_unexpected)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // input FIFO model: data appears one cycle after the pop
    logic [31:0] in_mem [256];
    int wr_idx = 0;
    int rd_idx = 0;
    assign bus.data_empty = (rd_idx == wr_idx);

    always @(posedge clock)
        if (bus.data_rd) begin
            bus.data_din <= in_mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end

    // worker lanes: result = request + 2 after lat[i] cycles, held until accepted
    logic [NL-1:0] hold, rdy_en, inj;
    int cnt [NL];
    int lat [NL];
    logic [31:0] ldat [NL];

    always_comb
        for (int i = 0; i < NL; i++) begin
            bus.lane_req_ready[i] = rdy_en[i] && !hold[i];
            bus.lane_rsp_valid[i] = (hold[i] && cnt[i] == 0) || inj[i];
            bus.lane_rsp_data[i*DW +: DW] = ldat[i];
        end

    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            hold <= '0;
            for (int i = 0; i < NL; i++) begin
                cnt[i]  <= 0;
                ldat[i] <= '0;
            end
        end else
            for (int i = 0; i < NL; i++) begin
                if (bus.lane_req_valid[i] && bus.lane_req_ready[i]) begin
                    hold[i] <= 1'b1;
                    cnt[i]  <= lat[i] - 1;
                    ldat[i] <= bus.lane_req_data[i*DW +: DW] + 32'd2;
                end else if (hold[i] && cnt[i] > 0)
                    cnt[i] <= cnt[i] - 1;
                if (hold[i] && bus.lane_rsp_valid[i] && bus.lane_rsp_ready[i]) hold[i] <= 1'b0;
            end

    // reference: popped words queue for dispatch, dispatched words queue for in-order output
    logic [31:0] pop_q [$];
    logic [31:0] exp_q [$];
    int lane_q [$];
    int disp_q [$];
    int m_dptr, m_cnt, rd_pulses, cyc;
    logic m_err, m_fired, m_rdlast, exp_wr;
    logic [31:0] exp_dout;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            pop_q.delete();
            exp_q.delete();
            lane_q.delete();
            m_dptr   <= 0;
            m_cnt    <= 0;
            m_err    <= 1'b0;
            m_fired  <= 1'b0;
            m_rdlast <= 1'b0;
            exp_wr   <= 1'b0;
            exp_dout <= '0;
        end else begin
            logic f;
            int d;
            logic [31:0] w;
            f = exp_q.size() > 0 && bus.lane_rsp_valid[lane_q[0]] && !bus.data_full && !m_fired;
            d = 0;
            if (f) begin
                w = exp_q.pop_front();
                exp_dout <= w;
                void'(lane_q.pop_front());
                d = -1;
            end
            for (int i = 0; i < NL; i++)
                if (bus.lane_req_valid[i] && bus.lane_req_ready[i]) begin
                    w = pop_q.pop_front();
                    exp_q.push_back(w + 32'd2);
                    lane_q.push_back(i);
                    disp_q.push_back(i);
                    m_dptr <= (m_dptr + 1) % NL;
                    d = d + 1;
                end
            if (bus.data_rd) begin
                pop_q.push_back(in_mem[rd_idx]);
                rd_pulses <= rd_pulses + 1;
            end
            for (int i = 0; i < NL; i++)
                if (bus.lane_rsp_valid[i] && !hold[i]) m_err <= 1'b1;
            m_cnt    <= m_cnt + d;
            exp_wr   <= f;
            m_fired  <= f;
            m_rdlast <= bus.data_rd;
        end

    always @(posedge clock) cyc <= cyc + 1;

    // per-cycle compare against the reference, plus output capture
    logic [31:0] obs_q [$];
    int obs_t [$];
    int peak = 0;

    always @(negedge clock)
        if (reset_n) begin
            logic [NL-1:0] ev, er;
            logic er_ok;
            ev = (pop_q.size() > 0 && !m_rdlast) ? NL'(1) << m_dptr : '0;
            er_ok = exp_q.size() > 0 && bus.lane_rsp_valid[lane_q[0]] && !bus.data_full && !m_fired;
            er = er_ok ? NL'(1) << lane_q[0] : '0;
            chk("data_rd", bus.data_rd, !bus.data_empty && !hold[m_dptr] && pop_q.size() == 0);
            chk("lane_req_valid", bus.lane_req_valid, ev);
            if (ev != 0) chk("lane_req_data", bus.lane_req_data[m_dptr*DW +: DW], pop_q[0]);
            chk("lane_rsp_ready", bus.lane_rsp_ready, er);
            chk("data_wr", bus.data_wr, exp_wr);
            chk("data_dout", bus.data_dout, exp_dout);
            chk("inflight", inflight, m_cnt);
            chk("err_unexpected", err_unexpected, m_err);
            if (bus.data_wr) begin
                obs_q.push_back(bus.data_dout);
                obs_t.push_back(cyc);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
        end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [31:0] v);
        in_mem[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_outs(input int n, input int budget, input string nm);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, obs_q.size() >= n, 1);
    endtask

    task automatic wait_sig(input int sel, input int v, input int budget, input string nm);
        int k = 0;
        while (((sel == 0) ? int'(inflight) : int'(bus.lane_req_valid)) != v && k < budget) begin
            tick();
            k++;
        end
        chk(nm, (sel == 0) ? int'(inflight) : int'(bus.lane_req_valid), v);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int exp_lanes [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int b;
        rdy_en = '1;
        inj = '0;
        bus.data_full = 1'b0;
        cyc = 0;
        rd_pulses = 0;
        for (int i = 0; i < NL; i++) lat[i] = 2;
        #1;
        chk("reset_data_rd", bus.data_rd, 0);
        chk("reset_req_valid", bus.lane_req_valid, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_data_wr", bus.data_wr, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // single word through lane 0
        push(32'h10);
        wait_outs(1, 60, "t1_timeout");
        chk("t1_dout", obs_q[0], 32'h12);
        chk("t1_rd_pulses", rd_pulses, 1);
        chk("t1_peak_inflight", peak, 1);
        repeat (3) tick();
        chk("t1_inflight_end", inflight, 0);

        // eight words across lanes with unequal latencies
        do_reset();
        lat[0] = 1; lat[1] = 7; lat[2] = 3; lat[3] = 5;
        b = obs_q.size();
        disp_q.delete();
        for (int k = 1; k <= 8; k++) push(32'(k));
        wait_outs(b + 8, 400, "t2_timeout");
        for (int k = 0; k < 8; k++) chk("t2_order", obs_q[b+k], 32'(k + 3));
        for (int k = 0; k < 8; k++) chk("t2_lane", disp_q[k], exp_lanes[k]);

        // lane 2 refuses requests for 20 cycles
        for (int i = 0; i < NL; i++) lat[i] = 2;
        rdy_en[2] = 1'b0;
        b = obs_q.size();
        push(32'h41); push(32'h42); push(32'h43);
        wait_sig(1, 4, 100, "t3_stall_lane2");
        push(32'h44);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("t3_valid_held", bus.lane_req_valid, 4'b0100);
            chk("t3_data_held", bus.lane_req_data[2*DW +: DW], 32'h43);
            chk("t3_no_rd", bus.data_rd, 0);
            tick();
        end
        rdy_en[2] = 1'b1;
        wait_outs(b + 4, 200, "t3_timeout");
        for (int k = 0; k < 4; k++) chk("t3_order", obs_q[b+k], 32'h43 + 32'(k));

        // output FIFO full with every lane holding a result
        bus.data_full = 1'b1;
        b = obs_q.size();
        for (int k = 0; k < 5; k++) push(32'h51 + 32'(k));
        wait_sig(0, 4, 200, "t4_inflight4");
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("t4_no_rd", bus.data_rd, 0);
            chk("t4_no_wr", bus.data_wr, 0);
            chk("t4_inflight", inflight, 4);
            tick();
        end
        bus.data_full = 1'b0;
        wait_outs(b + 5, 200, "t4_timeout");
        for (int k = 0; k < 5; k++) chk("t4_order", obs_q[b+k], 32'h53 + 32'(k));
        for (int k = 1; k < 4; k++) chk("t4_gap", obs_t[b+k] - obs_t[b+k-1] >= 2, 1);

        // response on an idle lane
        repeat (5) tick();
        chk("t5_err_before", err_unexpected, 0);
        inj[3] = 1'b1;
        @(negedge clock);
        chk("t5_ready3", bus.lane_rsp_ready[3], 0);
        tick();
        tick();
        chk("t5_err_set", err_unexpected, 1);
        inj[3] = 1'b0;
        repeat (5) tick();
        chk("t5_err_sticky", err_unexpected, 1);

        // asynchronous reset with three lanes busy and a fourth word in ISSUE
        do_reset();
        for (int i = 0; i < NL; i++) lat[i] = 100;
        rdy_en[3] = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h31 + 32'(k));
        wait_sig(1, 8, 200, "t6_issue_lane3");
        wait_sig(0, 3, 20, "t6_inflight3");
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rd", bus.data_rd, 0);
        chk("t6_rst_req_valid", bus.lane_req_valid, 0);
        chk("t6_rst_req_data", bus.lane_req_data, 0);
        chk("t6_rst_rsp_ready", bus.lane_rsp_ready, 0);
        chk("t6_rst_wr", bus.data_wr, 0);
        chk("t6_rst_dout", bus.data_dout, 0);
        chk("t6_rst_inflight", inflight, 0);
        chk("t6_rst_err", err_unexpected, 0);
        for (int i = 0; i < NL; i++) lat[i] = 2;
        rdy_en = '1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        b = obs_q.size();
        push(32'h20);
        wait_sig(1, 1, 20, "t6_lane0");
        wait_outs(b + 1, 60, "t6_timeout");
        chk("t6_dout", obs_q[b], 32'h22);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
